// File: rtl/ocp_pkg.sv
// Shared OCP-style command/response encodings and field widths for the scratchpad core.
package ocp_pkg;

  localparam int CMD_W  = 3;
  localparam int RESP_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_IDLE = 3'b000,
    CMD_WR   = 3'b001,
    CMD_RD   = 3'b010
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NULL = 2'b00,
    RESP_DVA  = 2'b01,
    RESP_FAIL = 2'b10,
    RESP_ERR  = 2'b11
  } resp_e;

  // Response a command earns at acceptance; reserved codes and out-of-range accesses get ERR.
  function automatic logic [RESP_W-1:0] cmd_resp(input logic [CMD_W-1:0] cmd,
                                                 input logic             out_of_range);
    logic [RESP_W-1:0] r;
    r = RESP_ERR;
    if (cmd == CMD_IDLE) begin
      r = RESP_NULL;
    end else if ((cmd == CMD_WR || cmd == CMD_RD) && !out_of_range) begin
      r = RESP_DVA;
    end
    return r;
  endfunction

endpackage

// File: rtl/spm_bytewise_ram.sv
// DEPTH x DATA_W single-port array with per-byte write enables and a registered read port.
module spm_bytewise_ram #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 128,
  localparam int BYTES  = DATA_W / 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BYTES-1:0]  be,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or read register so the tools can map this onto block RAM.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata <= mem[idx];
    end
    for (int b = 0; b < BYTES; b++) begin
      if (we && be[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/spm_ocp_core.sv
// Parametrised scratchpad with an OCP-style core port; optional upper-address range check
// is enabled by defining SPM_RANGE_CHECK_EN.
module spm_ocp_core
  import ocp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CMD_W-1:0]      io_M_Cmd,
  input  logic [ADDR_W-1:0]     io_M_Addr,
  input  logic [DATA_W-1:0]     io_M_Data,
  input  logic [DATA_W/8-1:0]   io_M_ByteEn,
  output logic [RESP_W-1:0]     io_S_Resp,
  output logic [DATA_W-1:0]     io_S_Data
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX   = $clog2(DEPTH);

  // Handshake: the slave is always ready. Every cycle's Cmd is accepted at the rising edge
  // and yields exactly one response (NULL/DVA/ERR) RD_LAT cycles later, strictly in order.

  logic [IDX-1:0]    word_idx;
  logic              out_of_range;
  logic              is_wr;
  logic              is_rd;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr;

  assign word_idx    = io_M_Addr[OFF+IDX-1:OFF];
  assign unused_addr = ^io_M_Addr;

`ifdef SPM_RANGE_CHECK_EN
  assign out_of_range = (io_M_Addr >> (OFF + IDX)) != '0;
`else
  assign out_of_range = 1'b0;
`endif

  assign is_wr = (io_M_Cmd == CMD_WR) && !out_of_range;
  assign is_rd = (io_M_Cmd == CMD_RD) && !out_of_range;

  spm_bytewise_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (is_wr),
    .be     (io_M_ByteEn),
    .rd_en  (is_rd),
    .idx    (word_idx),
    .wdata  (io_M_Data),
    .rdata  (ram_rdata)
  );

  logic [RESP_W-1:0] resp1;
  logic              rd1;
  logic [DATA_W-1:0] data1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp1 <= RESP_NULL;
      rd1   <= 1'b0;
    end else begin
      resp1 <= cmd_resp(io_M_Cmd, out_of_range);
      rd1   <= is_rd;
    end
  end

  // The RAM read register holds stale data on non-read cycles, so gate it here.
  assign data1 = rd1 ? ram_rdata : '0;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [RESP_W-1:0] resp2;
      logic [DATA_W-1:0] data2;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          resp2 <= RESP_NULL;
          data2 <= '0;
        end else begin
          resp2 <= resp1;
          data2 <= data1;
        end
      end

      assign io_S_Resp = resp2;
      assign io_S_Data = data2;
    end else begin : g_lat1
      assign io_S_Resp = resp1;
      assign io_S_Data = data1;
    end
  endgenerate

endmodule

// File: tb/tb_spm_ocp_core.sv
// Scoreboard bench for spm_ocp_core: one instance at RD_LAT=1 and one at RD_LAT=2 share stimulus.
module tb_spm_ocp_core;
  import ocp_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 16;
  localparam int OFF    = 2;
  localparam int IDX    = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [2:0]        cmd = 3'b000;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [3:0]        be = '0;
  logic [1:0]        resp1, resp2;
  logic [DATA_W-1:0] data1, data2;

  always #5 clk = ~clk;

  spm_ocp_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .io_M_Cmd(cmd), .io_M_Addr(addr), .io_M_Data(wdata),
    .io_M_ByteEn(be), .io_S_Resp(resp1), .io_S_Data(data1)
  );

  spm_ocp_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .io_M_Cmd(cmd), .io_M_Addr(addr), .io_M_Data(wdata),
    .io_M_ByteEn(be), .io_S_Resp(resp2), .io_S_Data(data2)
  );

  // Entry layout: {due_cycle[15:0], resp[1:0], data[31:0]}
  logic [49:0]       exp_q1[$];
  logic [49:0]       exp_q2[$];
  logic [49:0]       e1, e2;
  logic [DATA_W-1:0] model [DEPTH];
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    logic [1:0]  er;
    logic [31:0] ed;
    logic        oor;
    int          w;
    @(negedge clk);
    cmd = c; addr = a; wdata = d; be = b;
`ifdef SPM_RANGE_CHECK_EN
    oor = (a >> (OFF + IDX)) != 0;
`else
    oor = 1'b0;
`endif
    w  = int'(a[OFF+IDX-1:OFF]);
    er = RESP_ERR;
    ed = '0;
    if (c == CMD_IDLE) begin
      er = RESP_NULL;
    end else if (c == CMD_WR && !oor) begin
      er = RESP_DVA;
      for (int i = 0; i < 4; i++) if (b[i]) model[w][8*i +: 8] = d[8*i +: 8];
    end else if (c == CMD_RD && !oor) begin
      er = RESP_DVA;
      ed = model[w];
    end
    exp_q1.push_back({16'(cyc + 1), er, ed});
    exp_q2.push_back({16'(cyc + 2), er, ed});
  endtask

  always @(negedge clk) begin
    if (reset) begin
      while (exp_q1.size() != 0 && exp_q1[0][49:34] == 16'(cyc)) begin
        e1 = exp_q1.pop_front();
        check_val("lat1_resp", 64'(resp1), 64'(e1[33:32]));
        check_val("lat1_data", 64'(data1), 64'(e1[31:0]));
      end
      while (exp_q2.size() != 0 && exp_q2[0][49:34] == 16'(cyc)) begin
        e2 = exp_q2.pop_front();
        check_val("lat2_resp", 64'(resp2), 64'(e2[33:32]));
        check_val("lat2_data", 64'(data2), 64'(e2[31:0]));
      end
    end
  end

  initial begin
    #1;
    check_val("reset_resp1", 64'(resp1), 64'(RESP_NULL));
    check_val("reset_data1", 64'(data1), 64'h0);
    check_val("reset_resp2", 64'(resp2), 64'(RESP_NULL));
    check_val("reset_data2", 64'(data2), 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Streaming: alternating full-word WR / RD over every word, low address bits randomised.
    for (int i = 0; i < DEPTH; i++) begin
      drive(CMD_WR, 16'((i << OFF) | $urandom_range(0, 3)), $urandom, 4'hF);
      drive(CMD_RD, 16'(i << OFF), 32'h0, 4'h0);
    end

    drive(CMD_WR, 16'h0010, 32'hDEADBEEF, 4'hF);
    drive(CMD_RD, 16'h0010, 32'h0, 4'h0);

    drive(CMD_WR, 16'h0020, 32'h11223344, 4'hF);
    drive(CMD_WR, 16'h0020, 32'hAABBCCDD, 4'b0101);
    drive(CMD_RD, 16'h0020, 32'h0, 4'h0);

    drive(CMD_WR, 16'h0010, 32'h0, 4'h0);
    drive(CMD_RD, 16'h0010, 32'h0, 4'h0);

    drive(3'b011, 16'h0010, 32'hFFFFFFFF, 4'hF);
    drive(3'b111, 16'h0010, 32'hFFFFFFFF, 4'hF);
    drive(CMD_IDLE, 16'h0010, 32'h0, 4'h0);
    drive(CMD_RD, 16'h0010, 32'h0, 4'h0);

    drive(CMD_RD, 16'h0200, 32'h0, 4'h0);
    drive(CMD_WR, 16'h0204, 32'hCAFEF00D, 4'hF);
    drive(CMD_RD, 16'h0004, 32'h0, 4'h0);
    drive(CMD_RD, 16'h0204, 32'h0, 4'h0);

    repeat (200) begin
      case ($urandom_range(0, 9))
        0:       drive(CMD_IDLE, 16'($urandom), 32'h0, 4'h0);
        1:       drive(3'($urandom_range(3, 7)), 16'($urandom_range(0, 16'h3FF)), $urandom, 4'hF);
        2, 3, 4: drive(CMD_WR, 16'($urandom_range(0, 16'h3FF)), $urandom, 4'($urandom));
        default: drive(CMD_RD, 16'($urandom_range(0, 16'h3FF)), 32'h0, 4'h0);
      endcase
    end

    // Asynchronous reset with a read in flight in both pipelines.
    drive(CMD_RD, 16'h0010, 32'h0, 4'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    cmd = CMD_IDLE;
    #1;
    check_val("async_rst_resp1", 64'(resp1), 64'(RESP_NULL));
    check_val("async_rst_data1", 64'(data1), 64'h0);
    check_val("async_rst_resp2", 64'(resp2), 64'(RESP_NULL));
    check_val("async_rst_data2", 64'(data2), 64'h0);
    exp_q1.delete();
    exp_q2.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    repeat (3) drive(CMD_IDLE, 16'h0, 32'h0, 4'h0);
    drive(CMD_RD, 16'h0020, 32'h0, 4'h0);
    drive(CMD_RD, 16'h0010, 32'h0, 4'h0);
    repeat (3) drive(CMD_IDLE, 16'h0, 32'h0, 4'h0);

    repeat (4) @(negedge clk);
    #1;
    check_val("q1_drained", 64'(exp_q1.size()), 64'h0);
    check_val("q2_drained", 64'(exp_q2.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spm_ocp_core.md
Name: spm_ocp_core

Overview:
- Parametrised, single-port scratchpad memory with an OCP-style core interface.
- Successor to the fixed 128x32 SPM. Adds:
  - generic width and depth
  - per-byte write enables
  - explicit command/response handshake
  - configurable read latency
- Sits on the processor data path as the local data/instruction scratchpad behind the memory-stage arbitration.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8, 8..128.
- DEPTH, 128, number of words; power of two, at least 2.
- ADDR_W, 16, byte-address width; must be at least log2(DEPTH)+log2(DATA_W/8).
- RD_LAT, 1, read latency in cycles, 1 or 2; also applies to write acknowledges.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_M_Cmd  in  3  command: 000 IDLE, 001 WR, 010 RD, others reserved.
- io_M_Addr  in  ADDR_W  byte address.
- io_M_Data  in  DATA_W  write data.
- io_M_ByteEn  in  DATA_W/8  byte-lane write enables; bit i covers Data[8i+7:8i].
- io_S_Resp  out  2  response: 00 NULL, 01 DVA, 10 FAIL, 11 ERR.
- io_S_Data  out  DATA_W  read data, valid when Resp is DVA for a RD.

Behaviour:
- Address decode:
  - BYTES = DATA_W/8, OFF = log2(BYTES), IDX = log2(DEPTH).
  - Word index = M_Addr[OFF+IDX-1:OFF]; low OFF bits ignored.
- Accepts one command per cycle; no stall, no backpressure; slave always ready.
- WR:
  - At the accepting clock edge, each byte lane with ByteEn=1 is written; lanes with 0 keep their old value.
  - ByteEn=0 still writes nothing and is still acknowledged.
- RD:
  - Array read at the accepting edge.
  - Data reflects all writes accepted on earlier edges (a WR then RD to the same address on consecutive cycles returns the new data).
- Response pipeline, RD_LAT stages:
  - Every accepted WR/RD produces exactly one DVA response RD_LAT cycles after acceptance.
  - Back-to-back commands produce back-to-back responses in order.
- Reserved Cmd values produce an ERR response at the same latency, with no array access.
- IDLE produces a NULL response.
- io_S_Data is all zeros whenever Resp is not DVA-for-RD, including write acknowledges, NULL and ERR.
- RD_LAT=2 adds one output register stage after the array read register. Throughput stays one per cycle.
- Reset (asserted low, asynchronous):
  - Clears all response stages: io_S_Resp=NULL, io_S_Data=0 immediately.
  - In-flight responses are dropped.
  - Array contents are not reset.
  - A write accepted on the same edge that reset deasserts is not guaranteed; bench holds Cmd=IDLE for one cycle after deassertion.
- Simulation only: array initialised to X-free random values; outputs never X after reset.

Optional Feature:
- Macro: SPM_RANGE_CHECK_EN.
- Defined:
  - Any RD/WR with a nonzero M_Addr bit above OFF+IDX-1 gets an ERR response at normal latency.
  - Such a WR performs no write; such a RD returns Data 0.
- Undefined:
  - Upper address bits are ignored and accesses alias modulo DEPTH words, always DVA.
  - No extra logic is generated.

Decomposition:
- Shared package ocp_pkg holds:
  - Cmd encodings: CMD_IDLE, CMD_WR, CMD_RD.
  - Resp encodings: RESP_NULL, RESP_DVA, RESP_FAIL, RESP_ERR.
  - Field widths: CMD_W=3, RESP_W=2.
- One sub-module, spm_bytewise_ram:
  - DEPTH x DATA_W array with per-byte write enable and registered synchronous read.
  - Keeps the array inferable as block RAM.
- The top holds decode, the optional range check, and the response/latency pipeline.

Test Plan:
- Reset: drive reset=0 mid-stream with a RD in flight -> io_S_Resp=00 and io_S_Data=0 immediately; no DVA emerges after release.
- Full-word: WR addr 0x0010 data 0xDEADBEEF ByteEn 1111, then RD 0x0010 -> DVA after RD_LAT with 0xDEADBEEF; the WR ack is DVA with data 0.
- Byte enables: WR 0x0020 0x11223344 ByteEn 1111, then WR 0x0020 0xAABBCCDD ByteEn 0101, then RD -> 0x11BB33DD.
- Streaming: alternating WR/RD to addresses 0..127 with no idle cycles, at RD_LAT=1 and RD_LAT=2 -> one in-order response per cycle, all read data matching the model.
- Boundaries: reserved Cmd 011 -> ERR with data 0 and memory unchanged; IDLE -> NULL.
- Aliasing: RD 0x0200 with DEPTH=128 -> SPM_RANGE_CHECK_EN defined gives ERR with data 0; undefined gives DVA with word 0's contents.
